// File: rtl/video_pkg.sv
// Shared definitions for the raster video source blocks: FSM states,
// pixel output modes, RGB byte lanes and the gray helper.
package video_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_DRAIN = 3'd4
    } vstate_e;

    localparam logic [1:0] MODE_RGB     = 2'd0;
    localparam logic [1:0] MODE_GRAY    = 2'd1;
    localparam logic [1:0] MODE_INVGRAY = 2'd2;
    localparam logic [1:0] MODE_INVRGB  = 2'd3;

    localparam int LANE_R = 16;
    localparam int LANE_G = 8;
    localparam int LANE_B = 0;

    // Exact floor((R+G+B)/3); the 10-bit sum cannot overflow (max 765).
    function automatic logic [7:0] gray_of(input logic [23:0] px);
        logic [9:0] sum;
        sum = 10'(px[LANE_R +: 8]) + 10'(px[LANE_G +: 8]) + 10'(px[LANE_B +: 8]);
        return 8'(sum / 10'd3);
    endfunction

endpackage

// File: rtl/pixel_mode_convert.sv
// Combinational pixel conversion: passthrough, gray, inverted gray or
// inverted RGB on a packed {R,G,B} word.
module pixel_mode_convert
    import video_pkg::*;
(
    input  logic [23:0] pix_i,
    input  logic [1:0]  mode_i,
    output logic [23:0] pix_o
);

    logic [7:0] gray;

    always_comb begin
        gray  = gray_of(pix_i);
        pix_o = pix_i;
        case (mode_i)
            MODE_GRAY:    pix_o = {gray, gray, gray};
            MODE_INVGRAY: pix_o = {~gray, ~gray, ~gray};
            MODE_INVRGB:  pix_o = ~pix_i;
            default:      pix_o = pix_i;
        endcase
    end

endmodule

// File: rtl/video_frame_streamer.sv
// Raster video source: reads a frame buffer with 1-cycle read latency and
// streams converted pixels with VSYNC/HSYNC framing on a DE/ready handshake.
//   state | meaning
//   IDLE  | waiting for start
//   VSYNC | frame sync, VSYNC_DELAY cycles
//   HSYNC | line preamble, HSYNC high for its first 2 cycles
//   DATA  | one frame-buffer read per ready cycle
//   DRAIN | wait for the line's last pixel to leave
module video_frame_streamer
    import video_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int VSYNC_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int BOTTOM_UP   = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    input  logic              out_ready,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic              DE,
    output logic [7:0]        DATA_R,
    output logic [7:0]        DATA_G,
    output logic [7:0]        DATA_B,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CNT_MAX = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_DELAY - 1);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_DELAY - 1);

    vstate_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        mode_q, mode_d;
    logic              rd_q;
    logic              de_q, de_d;
    logic [23:0]       pix_q, pix_d;
    logic [23:0]       skid_q, skid_d;
    logic              skid_v_q, skid_v_d;

    logic              rd_c;
    logic              drain_ok;
    logic              done_c;
    logic [23:0]       conv_pix;
    logic [ADDR_W-1:0] row_img;
    logic [ADDR_W-1:0] addr_calc;

    pixel_mode_convert u_convert (
        .pix_i  (mem_rdata),
        .mode_i (mode_q),
        .pix_o  (conv_pix)
    );

    always_comb begin
        row_img   = (BOTTOM_UP != 0) ? (ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q)) : ADDR_W'(row_q);
        addr_calc = row_img * ADDR_W'(WIDTH) + ADDR_W'(col_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        row_d    = row_q;
        mode_d   = mode_q;
        done_c   = 1'b0;
        rd_c     = (state_q == ST_DATA) && out_ready;
        drain_ok = !rd_q && !skid_v_q && (!de_q || out_ready);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_VSYNC;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    mode_d  = mode;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_HSYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HSYNC: begin
                if (cnt_q == HS_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rd_c) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_ok) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        done_c  = 1'b1;
                    end else begin
                        state_d = ST_HSYNC;
                        row_d   = row_q + ROW_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage with a 1-entry skid: a return arriving while the
    // output is stalled is parked and emitted before anything newer.
    always_comb begin
        de_d     = de_q;
        pix_d    = pix_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (!de_q || out_ready) begin
            if (skid_v_q) begin
                pix_d    = skid_q;
                de_d     = 1'b1;
                skid_v_d = 1'b0;
            end else if (rd_q) begin
                pix_d = conv_pix;
                de_d  = 1'b1;
            end else begin
                de_d = 1'b0;
            end
        end else if (rd_q) begin
            skid_d   = conv_pix;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= MODE_RGB;
            rd_q     <= 1'b0;
            de_q     <= 1'b0;
            pix_q    <= '0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            rd_q     <= rd_c;
            de_q     <= de_d;
            pix_q    <= pix_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign mem_rd     = rd_c;
    assign mem_addr   = rd_c ? addr_calc : '0;
    assign VSYNC      = (state_q == ST_VSYNC);
    assign HSYNC      = (state_q == ST_HSYNC) && (cnt_q <= CNT_W'(1));
    assign DE         = de_q;
    assign DATA_R     = pix_q[LANE_R +: 8];
    assign DATA_G     = pix_q[LANE_G +: 8];
    assign DATA_B     = pix_q[LANE_B +: 8];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_c;

endmodule

// File: tb/tb_video_frame_streamer.sv
// Self-checking bench for video_frame_streamer: a queue-based reference of the
// expected address and pixel streams plus hand-computed timing/pixel literals.
module tb_video_frame_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int VD = 5;
    localparam int HD = 4;
    localparam int AW = 4;
    localparam int FRAME_LEN = VD + H * (HD + W + 2);

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          out_ready = 1'b1;
    logic [23:0]   mem_rdata;
    logic          mem_rd, VSYNC, HSYNC, DE, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    DATA_R, DATA_G, DATA_B;

    logic          td_start = 1'b0;
    logic          td_ready = 1'b1;
    logic [23:0]   td_rdata;
    logic          td_mem_rd, td_VSYNC, td_HSYNC, td_DE, td_busy, td_frame_done;
    logic [AW-1:0] td_mem_addr;
    logic [7:0]    td_R, td_G, td_B;

    logic [23:0]   mem [0:15];

    video_frame_streamer #(.WIDTH(W), .HEIGHT(H), .VSYNC_DELAY(VD), .HSYNC_DELAY(HD),
                           .BOTTOM_UP(1), .ADDR_W(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_ready(out_ready), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
        .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
        .busy(busy), .frame_done(frame_done));

    video_frame_streamer #(.WIDTH(W), .HEIGHT(H), .VSYNC_DELAY(VD), .HSYNC_DELAY(HD),
                           .BOTTOM_UP(0), .ADDR_W(AW)) dut_td (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(td_start), .mode(2'd0),
        .mem_rd(td_mem_rd), .mem_addr(td_mem_addr), .mem_rdata(td_rdata),
        .out_ready(td_ready), .VSYNC(td_VSYNC), .HSYNC(td_HSYNC), .DE(td_DE),
        .DATA_R(td_R), .DATA_G(td_G), .DATA_B(td_B),
        .busy(td_busy), .frame_done(td_frame_done));

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Frame buffer with one cycle of read latency; garbage when not read.
    always @(posedge HCLK) begin
        mem_rdata <= mem_rd ? mem[mem_addr] : 24'($urandom());
        td_rdata  <= td_mem_rd ? mem[td_mem_addr] : 24'($urandom());
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected pixel for a memory word in a given mode.
    function automatic logic [23:0] model_px(input logic [23:0] p, input int m);
        int r, g, b, gr;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        gr = (r + g + b) / 3;
        case (m)
            1:       return {8'(gr), 8'(gr), 8'(gr)};
            2:       return {8'(255 - gr), 8'(255 - gr), 8'(255 - gr)};
            3:       return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
            default: return p;
        endcase
    endfunction

    logic [AW-1:0] exp_addr[$];
    logic [23:0]   exp_pix[$];

    task automatic load_frame(input int m);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_addr.push_back(AW'((H - 1 - r) * W + c));
                exp_pix.push_back(model_px(mem[(H - 1 - r) * W + c], m));
            end
    endtask

    int          t0 = 0;
    int          rdy_mode = 0;
    int          beats, hs_pulses, hs_run, vs_run;
    logic        first_rd;
    longint      first_addr;
    logic [23:0] last_px, prev_px, px;
    logic        prev_stall;

    initial forever begin
        @(posedge HCLK);
        #1;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !((cyc - t0) == 22 || (cyc - t0) == 23 ||
                                   (cyc - t0) == 24 || (cyc - t0) == 28);
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            prev_stall = 1'b0;
            hs_run     = 0;
            vs_run     = 0;
        end else begin
            px = {DATA_R, DATA_G, DATA_B};
            if (mem_rd) begin
                check("rd_only_when_ready", out_ready, 1);
                check("addr_expected", int'(exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) begin
                    if (first_rd) begin
                        first_addr = mem_addr;
                        first_rd   = 1'b0;
                    end
                    check("addr", mem_addr, exp_addr.pop_front());
                end
            end
            if (DE && out_ready) begin
                beats++;
                last_px = px;
                check("pix_expected", int'(exp_pix.size() != 0), 1);
                if (exp_pix.size() != 0) check("pix", px, exp_pix.pop_front());
            end
            if (prev_stall) check("stall_hold", {DE, px}, {1'b1, prev_px});
            prev_stall = DE && !out_ready;
            prev_px    = px;
            if (HSYNC) check("hsync_overlap", {DE, VSYNC}, 0);
            if (HSYNC) hs_run++;
            else if (hs_run != 0) begin
                check("hsync_len", hs_run, 2);
                hs_pulses++;
                hs_run = 0;
            end
            if (VSYNC) vs_run++;
            else if (vs_run != 0) begin
                check("vsync_len", vs_run, VD);
                vs_run = 0;
            end
            if (frame_done) check("done_all_delivered", exp_pix.size() + exp_addr.size(), 0);
        end
    end

    task automatic run_frame(input int m, input int exp_len, input bit prestarted,
                             input bit poke, input bit hold_start);
        int len;
        load_frame(m);
        first_rd  = 1'b1;
        beats     = 0;
        hs_pulses = 0;
        if (!prestarted) begin
            @(posedge HCLK);
            #1;
            start = 1'b1;
        end
        mode = 2'(m);
        t0   = cyc;
        @(posedge HCLK);
        #1;
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        check("accept_busy_vsync", {busy, VSYNC}, 2'b11);
        len = -1;
        for (int i = 0; i < 400 && len < 0; i++) begin
            @(negedge HCLK);
            if (poke && (cyc - t0) == 15) start = 1'b1;
            if (poke && (cyc - t0) == 16) start = 1'b0;
            if (frame_done) len = cyc - t0;
        end
        if (exp_len >= 0) check("frame_len", len, exp_len);
        else check("frame_seen", int'(len > 0), 1);
        if (hold_start) start = 1'b1;
        @(posedge HCLK);
        #1;
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int n, bad, len, cnt;
        longint first;
        for (int a = 0; a < 16; a++) mem[a] = {8'(a), 8'(a), 8'(a)};

        repeat (2) @(posedge HCLK);
        #1;
        check("reset_outputs", {mem_rd, mem_addr, VSYNC, HSYNC, DE, DATA_R, DATA_G, DATA_B,
                                busy, frame_done}, 0);
        HRESETn = 1'b1;

        // Baseline frame
        run_frame(0, FRAME_LEN, 0, 0, 0);
        check("base_first_addr", first_addr, 8);
        check("base_beats", beats, 12);
        check("base_hsync_pulses", hs_pulses, 3);
        check("base_last_px", last_px, 24'h030303);

        // Modes on {30,60,90}; start poked mid-frame, then start held across frame_done
        for (int a = 0; a < 16; a++) mem[a] = {8'd30, 8'd60, 8'd90};
        run_frame(1, FRAME_LEN, 0, 1, 0);
        check("mode1_px", last_px, 24'h3C3C3C);
        run_frame(2, FRAME_LEN, 0, 0, 1);
        check("mode2_px", last_px, 24'hC3C3C3);
        run_frame(3, FRAME_LEN, 1, 0, 0);
        check("mode3_px", last_px, 24'hE1C3A5);

        // Scripted backpressure: 3 cycles mid-line, 1 cycle at line end
        for (int a = 0; a < 16; a++) mem[a] = {8'(a), 8'(a), 8'(a)};
        rdy_mode = 2;
        run_frame(0, FRAME_LEN + 4, 0, 0, 0);
        check("bp_beats", beats, 12);
        rdy_mode = 0;

        // Reset during row 1
        load_frame(0);
        @(posedge HCLK);
        #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge HCLK);
        #1;
        start = 1'b0;
        repeat (21) @(negedge HCLK);
        check("pre_reset_busy", busy, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_reset_outputs", {mem_rd, mem_addr, VSYNC, HSYNC, DE, DATA_R, DATA_G, DATA_B,
                                      busy, frame_done}, 0);
        exp_addr.delete();
        exp_pix.delete();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge HCLK);
            if (frame_done || busy) cnt++;
        end
        check("no_done_after_reset", cnt, 0);
        run_frame(0, FRAME_LEN, 0, 0, 0);
        check("rst_first_addr", first_addr, 8);

        // Randomized frames: random memory, mode and backpressure
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 16; a++) mem[a] = 24'($urandom());
            run_frame(int'($urandom_range(0, 3)), -1, 0, 0, 0);
            check("rand_beats", beats, 12);
        end
        rdy_mode = 0;

        // Top-down instance
        for (int a = 0; a < 16; a++) mem[a] = {8'(a), 8'(a), 8'(a)};
        @(posedge HCLK);
        #1;
        td_start = 1'b1;
        t0       = cyc;
        @(posedge HCLK);
        #1;
        td_start = 1'b0;
        n = 0; bad = 0; first = -1; len = -1;
        for (int i = 0; i < 200 && len < 0; i++) begin
            @(negedge HCLK);
            if (td_mem_rd) begin
                if (first < 0) first = td_mem_addr;
                if (td_mem_addr != AW'(n)) bad++;
                n++;
            end
            if (td_frame_done) len = cyc - t0;
        end
        check("td_first_addr", first, 0);
        check("td_addr_order", bad, 0);
        check("td_reads", n, 12);
        check("td_frame_len", len, FRAME_LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
